// File: rtl/keypad_seq_checker_if.sv
// Keypad/game-controller bundle for keypad_seq_checker: arming, code, raw keypad lines and puzzle results.
// The design side uses the slave modport; the game controller / bench side uses master.
interface keypad_seq_checker_if #(
  parameter int NUM_COLS = 3,
  parameter int NUM_ROWS = 4,
  parameter int KEY_W    = 4,
  parameter int SEQ_LEN  = 6
);
  logic                     enable;
  logic [SEQ_LEN*KEY_W-1:0] code_in;
  logic [NUM_ROWS-1:0]      row_in;
  logic [NUM_COLS-1:0]      col_out;
  logic                     key_valid;
  logic [KEY_W-1:0]         key_idx;
  logic [KEY_W-1:0]         progress;
  logic                     strike;
  logic                     module_defused;

  modport master (
    output enable, code_in, row_in,
    input  col_out, key_valid, key_idx, progress, strike, module_defused
  );

  modport slave (
    input  enable, code_in, row_in,
    output col_out, key_valid, key_idx, progress, strike, module_defused
  );
endinterface

// File: rtl/keypad_seq_checker.sv
// Matrix keypad scanner with frame debounce and ordered-code checker for a defusal puzzle.
// Optional macro KEYPAD_STRIKE_LOCKOUT_EN: ignore presses for LOCKOUT_CYCLES cycles after each strike.
module keypad_seq_checker #(
  parameter int NUM_COLS        = 3,
  parameter int NUM_ROWS        = 4,
  parameter int KEY_W           = 4,
  parameter int SEQ_LEN         = 6,
  parameter int SCAN_DIV        = 65000,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int LOCKOUT_CYCLES  = 65000000
) (
  input  logic                  clock_65mhz,
  input  logic                  reset,
  keypad_seq_checker_if.slave   kp
);
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW       = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int SW       = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, ENTER, DONE} state_t;

  // Reset asserts asynchronously but is released in step with the clock.
  logic [1:0] rst_sync_reg;
  logic       rst_n;
  always_ff @(posedge clock_65mhz or negedge reset) begin
    if (!reset) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  logic [NUM_ROWS-1:0]      row_meta_reg, row_sync_reg;
  logic [DW-1:0]            dwell_reg;
  logic [CW-1:0]            col_reg;
  logic [NUM_KEYS-1:0]      frame_reg, frame_next, prev_frame_reg;
  logic [NUM_KEYS-1:0]      db_map_reg, db_prev_reg;
  logic [SW-1:0]            stable_reg, stable_next;
  logic                     col_strobe, frame_done, press_event;
  logic [KEY_W-1:0]         key_enc;
  logic                     key_valid_reg;
  logic [KEY_W-1:0]         key_idx_reg;
  state_t                   state_reg, state_next;
  logic [SEQ_LEN*KEY_W-1:0] code_reg;
  logic [KEY_W-1:0]         progress_reg, progress_next, progress_inc, expected_key;
  logic                     strike_reg, strike_next, code_load, lockout_active;

  assign col_strobe = kp.enable && (dwell_reg == DW'(SCAN_DIV - 1));
  assign frame_done = col_strobe && (col_reg == CW'(NUM_COLS - 1));

  for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
    assign kp.col_out[gi] = kp.enable && rst_n && (col_reg == CW'(gi));
  end

  // Key index is row*NUM_COLS+col, so each frame bit belongs to one column slot.
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_frame
    assign frame_next[gi] = (col_strobe && (col_reg == CW'(gi % NUM_COLS)))
                            ? row_sync_reg[gi / NUM_COLS] : frame_reg[gi];
  end

  always_comb begin
    stable_next = SW'(1);
    if (frame_next == prev_frame_reg)
      stable_next = (stable_reg == SW'(DEBOUNCE_FRAMES)) ? stable_reg : stable_reg + 1'b1;
  end

  assign press_event = kp.enable && (db_prev_reg == '0) && (db_map_reg != '0)
                       && ((db_map_reg & (db_map_reg - 1'b1)) == '0);

  always_comb begin
    key_enc = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (db_map_reg[i]) key_enc = KEY_W'(i);
  end

  always_ff @(posedge clock_65mhz or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_reg   <= '0;
      row_sync_reg   <= '0;
      dwell_reg      <= '0;
      col_reg        <= '0;
      frame_reg      <= '0;
      prev_frame_reg <= '0;
      stable_reg     <= '0;
      db_map_reg     <= '0;
      db_prev_reg    <= '0;
      key_valid_reg  <= 1'b0;
      key_idx_reg    <= '0;
    end else begin
      row_meta_reg  <= kp.row_in;
      row_sync_reg  <= row_meta_reg;
      frame_reg     <= frame_next;
      key_valid_reg <= press_event;
      if (press_event) key_idx_reg <= key_enc;
      if (kp.enable) begin
        db_prev_reg <= db_map_reg;
        if (col_strobe) begin
          dwell_reg <= '0;
          col_reg   <= (col_reg == CW'(NUM_COLS - 1)) ? '0 : col_reg + 1'b1;
        end else begin
          dwell_reg <= dwell_reg + 1'b1;
        end
      end
      if (frame_done) begin
        prev_frame_reg <= frame_next;
        stable_reg     <= stable_next;
        if (stable_next == SW'(DEBOUNCE_FRAMES)) db_map_reg <= frame_next;
      end
    end
  end

  always_comb begin
    expected_key = '0;
    for (int i = 0; i < SEQ_LEN; i++)
      if (progress_reg == KEY_W'(i)) expected_key = code_reg[i*KEY_W +: KEY_W];
  end
  assign progress_inc = progress_reg + 1'b1;

  always_comb begin
    state_next    = state_reg;
    progress_next = progress_reg;
    strike_next   = 1'b0;
    code_load     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (kp.enable) begin
          state_next = ENTER;
          code_load  = 1'b1;
        end
      end
      ENTER: begin
        if (key_valid_reg && !lockout_active) begin
          if (key_idx_reg == expected_key) begin
            progress_next = progress_inc;
            if (progress_inc == KEY_W'(SEQ_LEN)) state_next = DONE;
          end else begin
            strike_next   = 1'b1;
            progress_next = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_65mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      code_reg     <= '0;
      progress_reg <= '0;
      strike_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      progress_reg <= progress_next;
      strike_reg   <= strike_next;
      if (code_load) code_reg <= kp.code_in;
    end
  end

`ifdef KEYPAD_STRIKE_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  logic [LW-1:0] lockout_reg;
  always_ff @(posedge clock_65mhz or negedge rst_n) begin
    if (!rst_n)                 lockout_reg <= '0;
    else if (strike_next)       lockout_reg <= LW'(LOCKOUT_CYCLES);
    else if (lockout_reg != '0) lockout_reg <= lockout_reg - 1'b1;
  end
  assign lockout_active = (lockout_reg != '0);
`else
  // Lockout is compiled out; this constant is always false.
  assign lockout_active = (LOCKOUT_CYCLES < 0);
`endif

  assign kp.key_valid      = key_valid_reg;
  assign kp.key_idx        = key_idx_reg;
  assign kp.progress       = progress_reg;
  assign kp.strike         = strike_reg;
  assign kp.module_defused = (state_reg == DONE);
endmodule

// File: tb/tb_keypad_seq_checker.sv
// Directed bench for keypad_seq_checker on a 3x4 pad, code 10,0,8,5,6,3, SCAN_DIV=4, 2 debounce frames.
// Define KEYPAD_STRIKE_LOCKOUT_EN to also run the lockout scenario.
module tb_keypad_seq_checker;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] pressed = '0;
  logic [3:0]  row_drive;
  logic [23:0] code_vec;
  int          code_tbl [6] = '{10, 0, 8, 5, 6, 3};
  int          passed = 0;
  int          total = 0;
  int          cyc = 0, kv_cnt = 0, kv_idx = 0, kv_cycle = 0, st_cnt = 0, def_cycle = 0;
  logic        def_prev = 1'b0;

  always #5 clk = ~clk;

  keypad_seq_checker_if #(.NUM_COLS(3), .NUM_ROWS(4), .KEY_W(4), .SEQ_LEN(6)) kp ();

  keypad_seq_checker #(
    .NUM_COLS(3), .NUM_ROWS(4), .KEY_W(4), .SEQ_LEN(6),
    .SCAN_DIV(4), .DEBOUNCE_FRAMES(2), .LOCKOUT_CYCLES(200)
  ) dut (
    .clock_65mhz(clk),
    .reset(reset),
    .kp(kp)
  );

  // Keypad model: a row senses high when a pressed key sits on the driven column.
  always_comb begin
    row_drive = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && kp.col_out[c]) row_drive[r] = 1'b1;
  end
  assign kp.row_in  = row_drive;
  assign kp.code_in = code_vec;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (kp.key_valid) begin
      kv_cnt   <= kv_cnt + 1;
      kv_idx   <= int'(kp.key_idx);
      kv_cycle <= cyc;
    end
    if (kp.strike) st_cnt <= st_cnt + 1;
    def_prev <= kp.module_defused;
    if (kp.module_defused && !def_prev) def_cycle <= cyc;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_key(input int k);
    pressed[k] = 1'b1;
    wait_cycles(60);
    pressed[k] = 1'b0;
    wait_cycles(60);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    kp.enable = 1'b0;
    pressed = '0;
    wait_cycles(4);
    reset = 1'b1;
    wait_cycles(4);
    kp.enable = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    kp.enable = 1'b1;
    wait_cycles(3);
    total++; if (kp.col_out !== 3'b000) $display("FAIL reset_col_out: got %b expected 000", kp.col_out); else passed++;
    total++; if (kp.key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b expected 0", kp.key_valid); else passed++;
    total++; if (kp.key_idx !== 4'd0) $display("FAIL reset_key_idx: got %0d expected 0", kp.key_idx); else passed++;
    total++; if (kp.progress !== 4'd0) $display("FAIL reset_progress: got %0d expected 0", kp.progress); else passed++;
    total++; if (kp.strike !== 1'b0) $display("FAIL reset_strike: got %b expected 0", kp.strike); else passed++;
    total++; if (kp.module_defused !== 1'b0) $display("FAIL reset_defused: got %b expected 0", kp.module_defused); else passed++;
    kp.enable = 1'b0;
    reset = 1'b1;
    wait_cycles(4);
    total++; if (kp.col_out !== 3'b000) $display("FAIL idle_col_out: got %b expected 000", kp.col_out); else passed++;
    kp.enable = 1'b1;
    #1;
    total++; if (kp.col_out !== 3'b001) $display("FAIL scan_col0: got %b expected 001", kp.col_out); else passed++;
    wait_cycles(4);
    total++; if (kp.col_out !== 3'b010) $display("FAIL scan_col1: got %b expected 010", kp.col_out); else passed++;
    wait_cycles(8);
    total++; if (kp.col_out !== 3'b001) $display("FAIL scan_wrap: got %b expected 001", kp.col_out); else passed++;
  endtask

  task automatic test_sequence();
    int k0, s0;
    do_reset();
    k0 = kv_cnt; s0 = st_cnt;
    for (int i = 0; i < 6; i++) begin
      press_key(code_tbl[i]);
      total++; if (kp.progress !== 4'(i + 1)) $display("FAIL seq_progress_%0d: got %0d expected %0d", i, kp.progress, i + 1); else passed++;
      total++; if (kv_idx != code_tbl[i]) $display("FAIL seq_key_idx_%0d: got %0d expected %0d", i, kv_idx, code_tbl[i]); else passed++;
    end
    total++; if (kv_cnt - k0 != 6) $display("FAIL seq_valid_count: got %0d expected 6", kv_cnt - k0); else passed++;
    total++; if (kp.module_defused !== 1'b1) $display("FAIL seq_defused: got %b expected 1", kp.module_defused); else passed++;
    total++; if (def_cycle - kv_cycle != 1) $display("FAIL seq_defused_latency: got %0d expected 1", def_cycle - kv_cycle); else passed++;
    total++; if (st_cnt - s0 != 0) $display("FAIL seq_no_strike: got %0d expected 0", st_cnt - s0); else passed++;
    press_key(7);
    total++; if (st_cnt - s0 != 0) $display("FAIL done_no_strike: got %0d expected 0", st_cnt - s0); else passed++;
    total++; if (kp.progress !== 4'd6) $display("FAIL done_progress: got %0d expected 6", kp.progress); else passed++;
  endtask

  task automatic test_strike();
    int s0;
    do_reset();
    press_key(10);
    press_key(0);
    total++; if (kp.progress !== 4'd2) $display("FAIL strike_pre_progress: got %0d expected 2", kp.progress); else passed++;
    s0 = st_cnt;
    press_key(7);
    total++; if (st_cnt - s0 != 1) $display("FAIL strike_pulse_cycles: got %0d expected 1", st_cnt - s0); else passed++;
    total++; if (kp.progress !== 4'd0) $display("FAIL strike_progress: got %0d expected 0", kp.progress); else passed++;
    for (int i = 0; i < 6; i++) press_key(code_tbl[i]);
    total++; if (kp.module_defused !== 1'b1) $display("FAIL strike_redefuse: got %b expected 1", kp.module_defused); else passed++;
    total++; if (st_cnt - s0 != 1) $display("FAIL strike_total: got %0d expected 1", st_cnt - s0); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_key(10);
    press_key(0);
    reset = 1'b0;
    #1;
    total++; if (kp.progress !== 4'd0) $display("FAIL reset_mid_progress: got %0d expected 0", kp.progress); else passed++;
    reset = 1'b1;
  endtask

  task automatic test_hold();
    int k0, s0;
    do_reset();
    k0 = kv_cnt; s0 = st_cnt;
    pressed[10] = 1'b1;
    wait_cycles(600);
    total++; if (kv_cnt - k0 != 1) $display("FAIL hold_valid_count: got %0d expected 1", kv_cnt - k0); else passed++;
    total++; if (kv_idx != 10) $display("FAIL hold_key_idx: got %0d expected 10", kv_idx); else passed++;
    pressed[10] = 1'b0;
    wait_cycles(60);
    k0 = kv_cnt;
    pressed[0] = 1'b1; pressed[8] = 1'b1;
    wait_cycles(120);
    pressed = '0;
    wait_cycles(60);
    total++; if (kv_cnt - k0 != 0) $display("FAIL multi_valid_count: got %0d expected 0", kv_cnt - k0); else passed++;
    total++; if (st_cnt - s0 != 0) $display("FAIL multi_strike: got %0d expected 0", st_cnt - s0); else passed++;
    total++; if (kp.progress !== 4'd1) $display("FAIL multi_progress: got %0d expected 1", kp.progress); else passed++;
    k0 = kv_cnt;
    pressed[0] = 1'b1;
    wait_cycles(5);
    pressed[0] = 1'b0;
    wait_cycles(80);
    total++; if (kv_cnt - k0 != 0) $display("FAIL glitch_valid_count: got %0d expected 0", kv_cnt - k0); else passed++;
  endtask

  task automatic test_bounce();
    int k0;
    do_reset();
    k0 = kv_cnt;
    for (int j = 0; j < 40; j++) begin
      if (j % 3 == 0) pressed[10] = ~pressed[10];
      wait_cycles(1);
    end
    pressed[10] = 1'b1;
    wait_cycles(100);
    pressed[10] = 1'b0;
    wait_cycles(60);
    total++; if (kv_cnt - k0 != 1) $display("FAIL bounce_valid_count: got %0d expected 1", kv_cnt - k0); else passed++;
    total++; if (kv_idx != 10) $display("FAIL bounce_key_idx: got %0d expected 10", kv_idx); else passed++;
    total++; if (kp.progress !== 4'd1) $display("FAIL bounce_progress: got %0d expected 1", kp.progress); else passed++;
  endtask

  task automatic test_enable();
    int k0, s0, bad;
    do_reset();
    press_key(10); press_key(0); press_key(8);
    total++; if (kp.progress !== 4'd3) $display("FAIL enable_pre_progress: got %0d expected 3", kp.progress); else passed++;
    k0 = kv_cnt; s0 = st_cnt; bad = 0;
    kp.enable = 1'b0;
    pressed[1] = 1'b1;
    for (int j = 0; j < 100; j++) begin
      wait_cycles(1);
      if (kp.col_out !== 3'b000) bad++;
    end
    pressed[1] = 1'b0;
    total++; if (bad != 0) $display("FAIL disabled_col_out: got %0d nonzero cycles expected 0", bad); else passed++;
    total++; if (kv_cnt - k0 != 0) $display("FAIL disabled_valid: got %0d expected 0", kv_cnt - k0); else passed++;
    total++; if (st_cnt - s0 != 0) $display("FAIL disabled_strike: got %0d expected 0", st_cnt - s0); else passed++;
    total++; if (kp.progress !== 4'd3) $display("FAIL disabled_progress: got %0d expected 3", kp.progress); else passed++;
    kp.enable = 1'b1;
    press_key(5); press_key(6); press_key(3);
    total++; if (kp.module_defused !== 1'b1) $display("FAIL enable_resume_defused: got %b expected 1", kp.module_defused); else passed++;
  endtask

`ifdef KEYPAD_STRIKE_LOCKOUT_EN
  task automatic test_lockout();
    int s0, k0, n;
    do_reset();
    s0 = st_cnt;
    pressed[7] = 1'b1;
    n = 0;
    while (st_cnt == s0 && n < 200) begin
      wait_cycles(1);
      n++;
    end
    total++; if (st_cnt - s0 != 1) $display("FAIL lockout_first_strike: got %0d expected 1", st_cnt - s0); else passed++;
    pressed[7] = 1'b0;
    wait_cycles(50);
    k0 = kv_cnt;
    pressed[10] = 1'b1;
    wait_cycles(60);
    pressed[10] = 1'b0;
    total++; if (kv_cnt - k0 != 1) $display("FAIL lockout_display_valid: got %0d expected 1", kv_cnt - k0); else passed++;
    total++; if (st_cnt - s0 != 1) $display("FAIL lockout_no_strike: got %0d expected 1", st_cnt - s0); else passed++;
    total++; if (kp.progress !== 4'd0) $display("FAIL lockout_progress: got %0d expected 0", kp.progress); else passed++;
    wait_cycles(190);
    press_key(10);
    total++; if (kp.progress !== 4'd1) $display("FAIL lockout_after_progress: got %0d expected 1", kp.progress); else passed++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 6; i++) code_vec[i*4 +: 4] = 4'(code_tbl[i]);
    kp.enable = 1'b0;
    test_reset();
    test_sequence();
    test_strike();
    test_reset_mid();
    test_hold();
    test_bounce();
    test_enable();
`ifdef KEYPAD_STRIKE_LOCKOUT_EN
    test_lockout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
